pattern_sender: RTL and testbench
=================================

Name: pattern_sender

Overview:
- Drives the 3-code unlock sequence (start strobe, CODE_1, CODE_2, CODE_3, clear strobe) onto an action/code interface.
- Each action strobe is a single cycle, carrying a 4-bit code, and strobes are separated by programmable idle gaps.
- Used as the stimulus end of the code-entry protocol: bench self-test, loopback demo, or board auto-play.
- Optional corruption of CODE_2 exercises the receiver's failure path.

Parameters:
- CODE_1, 4'b0101, first code sent.
- CODE_2, 4'b1000, second code sent.
- CODE_3, 4'b0001, third code sent.
- GAP_CYCLES, 4, idle cycles after every strobe. Must be >= 1; elaboration-time error otherwise.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high.
- start_in, input, 1, request a sequence; sampled only in IDLE.
- corrupt_in, input, 1, sampled together with an accepted start_in; when 1, step 2 sends ~CODE_2.
- action_out, output, 1, one-cycle strobe per step.
- code_out, output, 4, code for the current strobe; 4'b0000 whenever action_out=0.
- busy_out, output, 1, high in every state except IDLE.
- done_out, output, 1, one-cycle pulse after the final gap.
- led_b_out, output, 1, equals busy_out (board indicator).

Behaviour:
- Reset (reset=1 at posedge, from any state):
  - state <= IDLE; step <= 0; gap counter <= 0; corrupt latch <= 0.
  - All outputs are 0 from the following cycle.
- Outputs are registered (Moore): they are a function of the current state and step only.
- States:
  - IDLE:
    - All outputs 0.
    - start_in=1 -> STROBE, step=0, corrupt latch <= corrupt_in.
    - start_in=0 -> stay in IDLE.
  - STROBE:
    - action_out=1.
    - code_out by step: step0 = 4'b0000 (start), step1 = CODE_1, step2 = CODE_2 (or ~CODE_2 if latched corrupt), step3 = CODE_3, step4 = 4'b0000 (clear/return).
    - Next cycle -> GAP, gap counter <= 0.
  - GAP:
    - action_out=0, code_out=0.
    - Gap counter increments each cycle.
    - After exactly GAP_CYCLES GAP cycles: if step<4, step <= step+1 and go to STROBE; if step=4, go to DONE.
  - DONE:
    - done_out=1 for one cycle, busy_out=1.
    - Next cycle -> IDLE.
- Timing: with start_in accepted in IDLE at cycle T:
  - Strobe k (k = 0..4) occurs at T+1+k*(GAP_CYCLES+1).
  - done_out occurs at T+1+5*(GAP_CYCLES+1).
  - Total busy duration is 5*(GAP_CYCLES+1)+1 cycles.
- start_in while busy is ignored and is not queued.
- Holding start_in high continuously gives back-to-back sequences: IDLE accepts in the cycle after DONE, so there is exactly 1 IDLE cycle between sequences.
- corrupt_in is ignored except at acceptance; changing it mid-sequence has no effect.
- The gap counter is $clog2(GAP_CYCLES+1) bits wide. The step counter is 3 bits; values 5-7 are unreachable and must decode to IDLE behaviour.
- Reset mid-sequence aborts immediately: no partial strobe is emitted after the reset edge and done_out stays 0.

Test Plan:
- Nominal, GAP_CYCLES=2, start_in pulse at cycle 10, corrupt_in=0:
  - action_out high at cycles 11, 14, 17, 20, 23 only.
  - code_out = 0000, 0101, 1000, 0001, 0000 at those cycles; 0 elsewhere.
  - done_out only at cycle 26; busy_out and led_b_out high for cycles 11-26.
- Corrupt, same timing with corrupt_in=1 at cycle 10 then 0: code_out at cycle 17 = 4'b0111; all other strobes unchanged.
- Ignored start: start_in pulses at cycles 15 and 20 during the sequence -> no extra strobes; IDLE at 27 with no new sequence.
- Back-to-back: start_in held high from cycle 10 -> second sequence's first strobe at cycle 28, done at 43.
- Mid-op reset: reset=1 at cycle 16 (during the GAP after the CODE_1 strobe at 14):
  - From cycle 17, all outputs are 0 and there is no strobe at 17.
  - A new start at cycle 30 gives its first strobe at 31 with code 0000.
- Loopback: connect to the code-entry checker with GAP_CYCLES=1.
  - Checker reaches SUCCESS after the step3 strobe and returns to its start state after step4.
  - With corrupt_in=1 the checker reaches FAILURE after step2.

Source files
------------

// File: rtl/pattern_sender_if.sv
// Action/code bus between the unlock-sequence sender and its consumer.
// master = sender side, slave = requester/observer side.
interface pattern_sender_if;
    logic       start_in;
    logic       corrupt_in;
    logic       action_out;
    logic [3:0] code_out;
    logic       busy_out;
    logic       done_out;
    logic       led_b_out;

    modport master (
        input  start_in, corrupt_in,
        output action_out, code_out, busy_out, done_out, led_b_out
    );

    modport slave (
        output start_in, corrupt_in,
        input  action_out, code_out, busy_out, done_out, led_b_out
    );
endinterface

// File: rtl/pattern_sender.sv
// Plays start / CODE_1 / CODE_2 / CODE_3 / clear as single-cycle strobes separated
// by GAP_CYCLES idle cycles, then pulses done. Outputs are registered.
module pattern_sender #(
    parameter logic [3:0] CODE_1     = 4'b0101,
    parameter logic [3:0] CODE_2     = 4'b1000,
    parameter logic [3:0] CODE_3     = 4'b0001,
    parameter int         GAP_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    pattern_sender_if.master  bus
);

    generate
        if (GAP_CYCLES < 1) begin : g_bad_gap
            $error("pattern_sender: GAP_CYCLES must be >= 1");
        end
    endgenerate

    localparam int              GW       = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [2:0]      LAST_STEP = 3'd4;

    typedef enum logic [1:0] {IDLE, STROBE, GAP, DONE} state_t;

    state_t        state, state_n;
    logic [2:0]    step, step_n;
    logic [GW-1:0] gap_cnt, gap_n;
    logic          corrupt_q, corrupt_n;

    logic          action_q, action_n;
    logic [3:0]    code_q, code_n;
    logic          busy_q, busy_n;
    logic          done_q, done_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            step      <= 3'd0;
            gap_cnt   <= '0;
            corrupt_q <= 1'b0;
            action_q  <= 1'b0;
            code_q    <= 4'b0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            step      <= step_n;
            gap_cnt   <= gap_n;
            corrupt_q <= corrupt_n;
            action_q  <= action_n;
            code_q    <= code_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        step_n    = step;
        gap_n     = gap_cnt;
        corrupt_n = corrupt_q;

        case (state)
            IDLE: begin
                if (bus.start_in) begin
                    state_n   = STROBE;
                    step_n    = 3'd0;
                    corrupt_n = bus.corrupt_in;
                end
            end
            STROBE: begin
                state_n = GAP;
                gap_n   = '0;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (step == LAST_STEP) begin
                        state_n = DONE;
                    end else begin
                        state_n = STROBE;
                        step_n  = step + 3'd1;
                    end
                end else begin
                    gap_n = gap_cnt + GW'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // An out-of-range step can only come from an upset; fall back to IDLE.
        if (state != IDLE && step > LAST_STEP)
            state_n = IDLE;

        // Output registers are loaded from the decode of the next state/step,
        // so they present the Moore outputs of the state being entered.
        action_n = (state_n == STROBE);
        code_n   = 4'b0000;
        if (action_n) begin
            case (step_n)
                3'd1:    code_n = CODE_1;
                3'd2:    code_n = corrupt_n ? ~CODE_2 : CODE_2;
                3'd3:    code_n = CODE_3;
                default: code_n = 4'b0000;
            endcase
        end
        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    assign bus.action_out = action_q;
    assign bus.code_out   = code_q;
    assign bus.busy_out   = busy_q;
    assign bus.done_out   = done_q;
    assign bus.led_b_out  = busy_q;

endmodule

// File: tb/tb_pattern_sender.sv
// Directed bench: dut0 uses GAP_CYCLES=2 for timing scenarios, dut1 uses GAP_CYCLES=1
// and feeds a small code-entry checker for the loopback scenario.
module tb_pattern_sender;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pattern_sender_if bus0();
    pattern_sender_if bus1();

    pattern_sender #(.GAP_CYCLES(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0.master));
    pattern_sender #(.GAP_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.master));

    int passed = 0;
    int total  = 0;

    // {action, code[3:0], busy, done, led}
    wire logic [7:0] obs0 = {bus0.action_out, bus0.code_out, bus0.busy_out, bus0.done_out, bus0.led_b_out};
    wire logic [7:0] obs1 = {bus1.action_out, bus1.code_out, bus1.busy_out, bus1.done_out, bus1.led_b_out};

    // Code-entry checker: 0 wait, 1 armed, 2 got1, 3 got2, 4 success, 5 failure
    int ck;
    always @(posedge clk) begin
        if (reset) ck <= 0;
        else if (bus1.action_out) begin
            if (bus1.code_out == 4'b0000)
                ck <= (ck == 0) ? 1 : ((ck >= 4) ? 0 : 5);
            else case (ck)
                0:       ck <= 0;
                1:       ck <= (bus1.code_out == 4'b0101) ? 2 : 5;
                2:       ck <= (bus1.code_out == 4'b1000) ? 3 : 5;
                3:       ck <= (bus1.code_out == 4'b0001) ? 4 : 5;
                default: ck <= 5;
            endcase
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        bus0.start_in = 1'b0; bus0.corrupt_in = 1'b0;
        bus1.start_in = 1'b0; bus1.corrupt_in = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus0.start_in = 1'b1; bus1.start_in = 1'b1;
        bus0.corrupt_in = 1'b0; bus1.corrupt_in = 1'b0;
        tick();
        tick();
        for (int c = 0; c < 3; c++) begin
            total++;
            if (obs0 !== 8'h00) $display("FAIL reset0 c=%0d got=%b exp=%b", c, obs0, 8'h00);
            else passed++;
            total++;
            if (obs1 !== 8'h00) $display("FAIL reset1 c=%0d got=%b exp=%b", c, obs1, 8'h00);
            else passed++;
            tick();
        end
        do_reset();
    endtask

    // Shared stimulus shape for nominal / corrupt / ignored-start runs on dut0.
    task automatic test_sequence(input string name, input bit corrupt, input bit extra_starts);
        int sc[5] = '{11, 14, 17, 20, 23};
        logic [3:0] cd[5] = '{4'b0000, 4'b0101, 4'b1000, 4'b0001, 4'b0000};
        logic [7:0] exp;
        if (corrupt) cd[2] = 4'b0111;
        do_reset();
        for (int c = 0; c <= 32; c++) begin
            bus0.start_in   = (c == 10) || (extra_starts && (c == 15 || c == 20));
            bus0.corrupt_in = (c == 10) ? corrupt : (extra_starts && (c == 15 || c == 20));
            exp = 8'h00;
            for (int k = 0; k < 5; k++)
                if (c == sc[k]) exp[7:3] = {1'b1, cd[k]};
            if (c >= 11 && c <= 26) begin exp[2] = 1'b1; exp[0] = 1'b1; end
            if (c == 26) exp[1] = 1'b1;
            total++;
            if (obs0 !== exp) $display("FAIL %s c=%0d got=%b exp=%b", name, c, obs0, exp);
            else passed++;
            tick();
        end
    endtask

    task automatic test_back_to_back;
        int sc[10] = '{11, 14, 17, 20, 23, 28, 31, 34, 37, 40};
        logic [3:0] cd[5] = '{4'b0000, 4'b0101, 4'b1000, 4'b0001, 4'b0000};
        logic [7:0] exp;
        do_reset();
        for (int c = 0; c <= 46; c++) begin
            bus0.start_in = (c >= 10 && c <= 42);
            exp = 8'h00;
            for (int k = 0; k < 10; k++)
                if (c == sc[k]) exp[7:3] = {1'b1, cd[k % 5]};
            if ((c >= 11 && c <= 26) || (c >= 28 && c <= 43)) begin exp[2] = 1'b1; exp[0] = 1'b1; end
            if (c == 26 || c == 43) exp[1] = 1'b1;
            total++;
            if (obs0 !== exp) $display("FAIL back_to_back c=%0d got=%b exp=%b", c, obs0, exp);
            else passed++;
            tick();
        end
        bus0.start_in = 1'b0;
    endtask

    task automatic test_mid_reset;
        logic [7:0] exp;
        do_reset();
        for (int c = 0; c <= 32; c++) begin
            bus0.start_in = (c == 10) || (c == 30);
            reset         = (c == 16);
            exp = 8'h00;
            if (c == 11 || c == 31) exp[7:3] = {1'b1, 4'b0000};
            if (c == 14)            exp[7:3] = {1'b1, 4'b0101};
            if ((c >= 11 && c <= 16) || c >= 31) begin exp[2] = 1'b1; exp[0] = 1'b1; end
            total++;
            if (obs0 !== exp) $display("FAIL mid_reset c=%0d got=%b exp=%b", c, obs0, exp);
            else passed++;
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic test_loopback(input bit corrupt);
        int sc[5] = '{11, 13, 15, 17, 19};
        logic [3:0] cd[5] = '{4'b0000, 4'b0101, 4'b1000, 4'b0001, 4'b0000};
        logic [7:0] exp;
        int exp_ck;
        if (corrupt) cd[2] = 4'b0111;
        do_reset();
        for (int c = 0; c <= 23; c++) begin
            bus1.start_in   = (c == 10);
            bus1.corrupt_in = (c == 10) && corrupt;
            exp = 8'h00;
            for (int k = 0; k < 5; k++)
                if (c == sc[k]) exp[7:3] = {1'b1, cd[k]};
            if (c >= 11 && c <= 21) begin exp[2] = 1'b1; exp[0] = 1'b1; end
            if (c == 21) exp[1] = 1'b1;
            total++;
            if (obs1 !== exp) $display("FAIL loopback%0d c=%0d got=%b exp=%b", corrupt, c, obs1, exp);
            else passed++;
            if (c == 16 || c == 18 || c == 20) begin
                if (c == 20)      exp_ck = 0;
                else if (corrupt) exp_ck = 5;
                else              exp_ck = (c == 16) ? 3 : 4;
                total++;
                if (ck !== exp_ck) $display("FAIL checker%0d c=%0d got=%0d exp=%0d", corrupt, c, ck, exp_ck);
                else passed++;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_sequence("nominal", 1'b0, 1'b0);
        test_sequence("corrupt", 1'b1, 1'b0);
        test_sequence("ignored_start", 1'b0, 1'b1);
        test_back_to_back();
        test_mid_reset();
        test_loopback(1'b0);
        test_loopback(1'b1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
